// File: rtl/spi_bridge_if.sv
// spi_bridge_if
//   Bundles the SPI pins and the decoder-side byte interface of spi_bridge.
//   slave modport  : used by spi_bridge (pins in, miso out, byte handshake out)
//   master modport : used by whatever drives the SPI pins and the decoder side
// Signals:
//   sclk, cs_n, mosi : SPI pins from the external master (async to clk)
//   miso             : SPI data back to the master
//   byte_sync        : one-cycle strobe, a received byte is valid on data_in
//   data_in[7:0]     : last received byte
//   data_out[7:0]    : response byte shifted out on miso
interface spi_bridge_if;
  logic       sclk;
  logic       cs_n;
  logic       mosi;
  logic       miso;
  logic       byte_sync;
  logic [7:0] data_in;
  logic [7:0] data_out;

  modport slave (
    input  sclk, cs_n, mosi, data_out,
    output miso, byte_sync, data_in
  );

  modport master (
    output sclk, cs_n, mosi, data_out,
    input  miso, byte_sync, data_in
  );
endinterface

// File: rtl/spi_bridge.sv
// spi_bridge
//   SPI mode-0 slave front end for the PWM instruction decoder. SPI pins are
//   oversampled in the clk domain, MOSI bits are assembled MSB first into
//   bytes announced by a one-cycle byte_sync, and the decoder's data_out byte
//   is shifted back out on MISO during the following byte.
// Parameters:
//   SYNC_STAGES : synchronizer depth on sclk, cs_n and mosi (legal 2..4)
// Ports:
//   clk   : peripheral clock
//   rst_n : asynchronous active-low reset
//   bus   : spi_bridge_if.slave (sclk, cs_n, mosi, miso, byte_sync,
//           data_in, data_out)
// Build option:
//   SPI_MISO_TRISTATE_EN : when defined, miso floats (1'bz) whenever the
//   synchronized cs_n is high, so several slaves can share the MISO line.
//   When undefined, miso is always driven from tx_shift[7].
module spi_bridge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  spi_bridge_if.slave  bus
);

  logic [SYNC_STAGES-1:0] r_sclk_sync;
  logic [SYNC_STAGES-1:0] r_cs_sync;
  logic [SYNC_STAGES-1:0] r_mosi_sync;
  logic                   r_sclk_d;
  logic                   r_cs_d;

  logic [7:0] r_rx_shift;
  logic [7:0] r_tx_shift;
  logic [2:0] r_bit_cnt;
  logic       r_byte_done;
  logic       r_byte_sync;
  logic [7:0] r_data_in;

  logic w_sclk_s;
  logic w_cs_s;
  logic w_mosi_s;
  logic w_active;
  logic w_sclk_rise;
  logic w_sclk_fall;
  logic w_cs_fall;
  logic w_cs_rise;

  // cs_n synchronizer resets high so a reset never looks like an open frame
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sclk_sync <= '0;
      r_cs_sync   <= '1;
      r_mosi_sync <= '0;
      r_sclk_d    <= 1'b0;
      r_cs_d      <= 1'b1;
    end else begin
      r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], bus.sclk};
      r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], bus.cs_n};
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], bus.mosi};
      r_sclk_d    <= w_sclk_s;
      r_cs_d      <= w_cs_s;
    end
  end

  assign w_sclk_s    = r_sclk_sync[SYNC_STAGES-1];
  assign w_cs_s      = r_cs_sync[SYNC_STAGES-1];
  assign w_mosi_s    = r_mosi_sync[SYNC_STAGES-1];
  assign w_active    = ~w_cs_s;
  assign w_sclk_rise = w_sclk_s & ~r_sclk_d;
  assign w_sclk_fall = ~w_sclk_s & r_sclk_d;
  assign w_cs_fall   = ~w_cs_s & r_cs_d;
  assign w_cs_rise   = w_cs_s & ~r_cs_d;

  // RX: bit_cnt wraps 7->0 naturally on the 8th rise; r_byte_done delays the
  // strobe one cycle so data_in picks up the fully shifted byte.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_shift  <= 8'h00;
      r_bit_cnt   <= 3'd0;
      r_byte_done <= 1'b0;
      r_byte_sync <= 1'b0;
      r_data_in   <= 8'h00;
    end else begin
      r_byte_done <= 1'b0;
      r_byte_sync <= r_byte_done;
      if (r_byte_done) begin
        r_data_in <= r_rx_shift;
      end
      if (w_cs_rise) begin
        r_bit_cnt <= 3'd0;
      end else if (w_active && w_sclk_rise) begin
        r_rx_shift  <= {r_rx_shift[6:0], w_mosi_s};
        r_bit_cnt   <= r_bit_cnt + 3'd1;
        r_byte_done <= (r_bit_cnt == 3'd7);
      end
    end
  end

  // TX: a falling sclk with bit_cnt == 0 is the byte boundary, where the next
  // response byte is loaded instead of shifting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tx_shift <= 8'h00;
    end else if (w_cs_fall) begin
      r_tx_shift <= bus.data_out;
    end else if (w_active && w_sclk_fall) begin
      if (r_bit_cnt == 3'd0) begin
        r_tx_shift <= bus.data_out;
      end else begin
        r_tx_shift <= {r_tx_shift[6:0], 1'b0};
      end
    end
  end

  assign bus.byte_sync = r_byte_sync;
  assign bus.data_in   = r_data_in;

`ifdef SPI_MISO_TRISTATE_EN
  assign bus.miso = w_cs_s ? 1'bz : r_tx_shift[7];
`else
  assign bus.miso = r_tx_shift[7];
`endif

endmodule

// File: tb/tb_spi_bridge.sv
// tb_spi_bridge
//   Directed bench for spi_bridge: f_clk = 10 x f_sclk (5 clk cycles per sclk
//   half period), SPI pins driven on the falling clk edge, outputs sampled on
//   the falling clk edge.
module tb_spi_bridge;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  int   last_rise = 0;

  logic [7:0] sync_q[$];
  int         lat_q[$];

  spi_bridge_if bus ();

  spi_bridge #(.SYNC_STAGES(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst_n && bus.byte_sync === 1'b1) begin
      sync_q.push_back(bus.data_in);
      lat_q.push_back(cyc - last_rise);
    end
  end

  task automatic half();
    repeat (5) @(negedge clk);
  endtask

  task automatic send_bit(input logic b, output logic r);
    bus.mosi = b;
    half();
    r = bus.miso;
    bus.sclk = 1'b1;
    last_rise = cyc;
    half();
    bus.sclk = 1'b0;
  endtask

  task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx);
    logic r;
    for (int i = 7; i >= 0; i--) begin
      send_bit(tx[i], r);
      rx[i] = r;
    end
  endtask

  task automatic frame_start();
    @(negedge clk);
    bus.cs_n = 1'b0;
    half();
  endtask

  task automatic frame_end();
    half();
    bus.cs_n = 1'b1;
    repeat (10) @(negedge clk);
  endtask

  task automatic test_reset();
    logic exp_miso;
`ifdef SPI_MISO_TRISTATE_EN
    exp_miso = 1'bz;
`else
    exp_miso = 1'b0;
`endif
    rst_n = 1'b0;
    bus.sclk = 1'b0;
    bus.cs_n = 1'b1;
    bus.mosi = 1'b0;
    bus.data_out = 8'h00;
    repeat (3) @(negedge clk);
    tests++;
    if (bus.byte_sync !== 1'b0) begin
      fails++;
      $display("FAIL reset_byte_sync got %b want 0", bus.byte_sync);
    end
    tests++;
    if (bus.data_in !== 8'h00) begin
      fails++;
      $display("FAIL reset_data_in got %h want 00", bus.data_in);
    end
    tests++;
    if (bus.miso !== exp_miso) begin
      fails++;
      $display("FAIL reset_miso got %b want %b", bus.miso, exp_miso);
    end
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    tests++;
    if (bus.miso !== exp_miso) begin
      fails++;
      $display("FAIL idle_miso got %b want %b", bus.miso, exp_miso);
    end
  endtask

  task automatic test_write();
    logic [7:0] rx;
    sync_q.delete();
    lat_q.delete();
    frame_start();
    spi_byte(8'h81, rx);
    spi_byte(8'h5A, rx);
    frame_end();
    tests++;
    if (sync_q.size() != 2) begin
      fails++;
      $display("FAIL write_count got %0d want 2", sync_q.size());
    end else begin
      tests++;
      if (sync_q[0] !== 8'h81) begin
        fails++;
        $display("FAIL write_byte0 got %h want 81", sync_q[0]);
      end
      tests++;
      if (sync_q[1] !== 8'h5A) begin
        fails++;
        $display("FAIL write_byte1 got %h want 5a", sync_q[1]);
      end
      tests++;
      if (lat_q[0] != 4) begin
        fails++;
        $display("FAIL write_latency0 got %0d want 4", lat_q[0]);
      end
      tests++;
      if (lat_q[1] != 4) begin
        fails++;
        $display("FAIL write_latency1 got %0d want 4", lat_q[1]);
      end
    end
    tests++;
    if (bus.data_in !== 8'h5A) begin
      fails++;
      $display("FAIL write_hold got %h want 5a", bus.data_in);
    end
  endtask

  task automatic test_abort();
    logic       r;
    logic [7:0] rx;
    sync_q.delete();
    frame_start();
    for (int i = 0; i < 5; i++) send_bit(1'b1, r);
    frame_end();
    tests++;
    if (sync_q.size() != 0) begin
      fails++;
      $display("FAIL abort_no_sync got %0d pulses want 0", sync_q.size());
    end
    tests++;
    if (bus.data_in !== 8'h5A) begin
      fails++;
      $display("FAIL abort_data_in got %h want 5a", bus.data_in);
    end
    frame_start();
    spi_byte(8'h3C, rx);
    frame_end();
    tests++;
    if (sync_q.size() != 1 || sync_q[0] !== 8'h3C) begin
      fails++;
      $display("FAIL abort_next got %0d pulses data %h want 1 pulse 3c",
               sync_q.size(), bus.data_in);
    end
  endtask

  task automatic test_read();
    logic [7:0] rx0, rx1;
    sync_q.delete();
    bus.data_out = 8'hC3;
    frame_start();
    spi_byte(8'h05, rx0);
    spi_byte(8'h00, rx1);
    frame_end();
    tests++;
    if (rx0 !== 8'hC3) begin
      fails++;
      $display("FAIL read_miso0 got %h want c3", rx0);
    end
    tests++;
    if (rx1 !== 8'hC3) begin
      fails++;
      $display("FAIL read_miso1 got %h want c3", rx1);
    end
    tests++;
    if (sync_q.size() != 2 || sync_q[0] !== 8'h05 || sync_q[1] !== 8'h00) begin
      fails++;
      $display("FAIL read_rx got %0d pulses last %h want 05,00",
               sync_q.size(), bus.data_in);
    end
  endtask

  task automatic test_response();
    logic [7:0] rx0, rx1;
    bus.data_out = 8'h11;
    frame_start();
    fork
      begin
        spi_byte(8'h22, rx0);
        spi_byte(8'h33, rx1);
      end
      begin
        int n;
        n = 0;
        while (bus.byte_sync !== 1'b1 && n < 200) begin
          @(negedge clk);
          n++;
        end
        tests++;
        if (n >= 200) begin
          fails++;
          $display("FAIL response_wait got no byte_sync want pulse within 200 cycles");
        end else begin
          repeat (2) @(negedge clk);
          bus.data_out = 8'hE7;
        end
      end
    join
    frame_end();
    tests++;
    if (rx0 !== 8'h11) begin
      fails++;
      $display("FAIL response_byte0 got %h want 11", rx0);
    end
    tests++;
    if (rx1 !== 8'hE7) begin
      fails++;
      $display("FAIL response_byte1 got %h want e7", rx1);
    end
  endtask

  task automatic test_reset_mid();
    logic       r;
    logic [7:0] rx;
    logic       exp_miso;
`ifdef SPI_MISO_TRISTATE_EN
    exp_miso = 1'bz;
`else
    exp_miso = 1'b0;
`endif
    sync_q.delete();
    bus.data_out = 8'hFF;
    frame_start();
    send_bit(1'b1, r);
    send_bit(1'b0, r);
    send_bit(1'b1, r);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    tests++;
    if (bus.byte_sync !== 1'b0 || bus.data_in !== 8'h00) begin
      fails++;
      $display("FAIL midreset_outputs got sync %b data %h want 0 00",
               bus.byte_sync, bus.data_in);
    end
    tests++;
    if (bus.miso !== exp_miso) begin
      fails++;
      $display("FAIL midreset_miso got %b want %b", bus.miso, exp_miso);
    end
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    tests++;
    if (sync_q.size() != 0) begin
      fails++;
      $display("FAIL midreset_no_sync got %0d pulses want 0", sync_q.size());
    end
    spi_byte(8'hA5, rx);
    frame_end();
    tests++;
    if (sync_q.size() != 1 || sync_q[0] !== 8'hA5) begin
      fails++;
      $display("FAIL midreset_next got %0d pulses data %h want 1 pulse a5",
               sync_q.size(), bus.data_in);
    end
    tests++;
    if (rx !== 8'hFF) begin
      fails++;
      $display("FAIL midreset_miso_byte got %h want ff", rx);
    end
  endtask

  task automatic test_tristate();
    logic exp_idle;
`ifdef SPI_MISO_TRISTATE_EN
    exp_idle = 1'bz;
`else
    exp_idle = 1'b1;
`endif
    bus.data_out = 8'h80;
    @(negedge clk);
    bus.cs_n = 1'b0;
    repeat (6) @(negedge clk);
    tests++;
    if (bus.miso !== 1'b1) begin
      fails++;
      $display("FAIL miso_selected got %b want 1", bus.miso);
    end
    bus.cs_n = 1'b1;
    repeat (6) @(negedge clk);
    tests++;
    if (bus.miso !== exp_idle) begin
      fails++;
      $display("FAIL miso_deselected got %b want %b", bus.miso, exp_idle);
    end
  endtask

  initial begin
    bus.sclk = 1'b0;
    bus.cs_n = 1'b1;
    bus.mosi = 1'b0;
    bus.data_out = 8'h00;
    test_reset();
    test_write();
    test_abort();
    test_read();
    test_response();
    test_reset_mid();
    test_tristate();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
